// File: rtl/sequence_stepper.sv
// Plays 128-bit words from the sequence ring buffer at a programmable clocks-per-step rate,
// substituting the all-zero safe word whenever the stepper is idle, aborted, done or underflowing.
module sequence_stepper #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable_i,
  input  logic [31:0]           step_period_i,
  input  logic [31:0]           total_steps_i,
  input  logic [31:0]           write_ptr_i,
  output logic                  bram_en_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  input  logic [127:0]          bram_rdata_i,
  output logic [127:0]          seq_data_o,
  output logic                  step_strobe_o,
  output logic [31:0]           step_counter_o,
  output logic                  running_o,
  output logic                  done_o,
  output logic                  underflow_o
);

  localparam logic [31:0] MIN_PERIOD = 32'd4;
  localparam logic [31:0] HALF_RANGE = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  prime_wait_q, prime_wait_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           period_q, period_d;
  logic [31:0]           step_q, step_d;
  logic [127:0]          seq_q, seq_d;
  logic                  strobe_q, strobe_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  avail_q, avail_d;
  logic                  done_q, done_d;
  logic                  underflow_q, underflow_d;

  logic [31:0] period_in;
  logic [31:0] period_cur;
  logic [31:0] next_step;
  logic [31:0] issue_step;
  logic [31:0] distance;
  logic        avail_now;
  logic        last_step;

  // The period is sampled during cnt == 0, so the fresh value already governs that step.
  // Availability uses a modular distance so it stays correct across 32-bit pointer wrap.
  always_comb begin
    period_in  = (step_period_i < MIN_PERIOD) ? MIN_PERIOD : step_period_i;
    period_cur = (cnt_q == 32'd0) ? period_in : period_q;
    next_step  = step_q + 32'd1;
    issue_step = (state_q == PRIME) ? 32'd0 : next_step;
    distance   = write_ptr_i - issue_step;
    avail_now  = (distance != 32'd0) && (distance <= HALF_RANGE);
    last_step  = (total_steps_i != 32'd0) && (next_step == total_steps_i);
  end

  always_comb begin
    state_d      = state_q;
    prime_wait_d = prime_wait_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    step_d       = step_q;
    seq_d        = seq_q;
    strobe_d     = 1'b0;
    en_d         = 1'b0;
    addr_d       = addr_q;
    avail_d      = avail_q;
    done_d       = done_q;
    underflow_d  = underflow_q;

    unique case (state_q)
      IDLE: begin
        seq_d  = '0;
        done_d = 1'b0;
        if (enable_i) begin
          state_d      = PRIME;
          prime_wait_d = 1'b0;
          step_d       = 32'd0;
          underflow_d  = 1'b0;
          en_d         = 1'b1;
          addr_d       = '0;
        end
      end

      PRIME: begin
        if (!enable_i) begin
          state_d = IDLE;
          seq_d   = '0;
        end else if (!prime_wait_q) begin
          avail_d      = avail_now;
          prime_wait_d = 1'b1;
        end else begin
          seq_d    = avail_q ? bram_rdata_i : '0;
          strobe_d = 1'b1;
          cnt_d    = 32'd0;
          state_d  = RUN;
          if (!avail_q) begin
            underflow_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          seq_d   = '0;
        end else begin
          if (cnt_q == 32'd0) begin
            period_d = period_in;
          end
          if (cnt_q == period_cur - 32'd1) begin
            if (last_step) begin
              state_d = DONE;
              seq_d   = '0;
              done_d  = 1'b1;
            end else begin
              seq_d    = avail_q ? bram_rdata_i : '0;
              step_d   = next_step;
              cnt_d    = 32'd0;
              strobe_d = 1'b1;
              if (!avail_q) begin
                underflow_d = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
            // Read enable is registered, so it is armed one cycle ahead of the issue cycle.
            if ((cnt_q == period_cur - 32'd3) && !last_step) begin
              en_d   = 1'b1;
              addr_d = next_step[ADDR_WIDTH-1:0];
            end
            if (cnt_q == period_cur - 32'd2) begin
              avail_d = avail_now;
            end
          end
        end
      end

      DONE: begin
        seq_d  = '0;
        done_d = 1'b1;
        if (!enable_i) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        seq_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      prime_wait_q <= 1'b0;
      cnt_q        <= '0;
      period_q     <= '0;
      step_q       <= '0;
      seq_q        <= '0;
      strobe_q     <= 1'b0;
      en_q         <= 1'b0;
      addr_q       <= '0;
      avail_q      <= 1'b0;
      done_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prime_wait_q <= prime_wait_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      step_q       <= step_d;
      seq_q        <= seq_d;
      strobe_q     <= strobe_d;
      en_q         <= en_d;
      addr_q       <= addr_d;
      avail_q      <= avail_d;
      done_q       <= done_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bram_en_o      = en_q;
  assign bram_addr_o    = addr_q;
  assign seq_data_o     = seq_q;
  assign step_strobe_o  = strobe_q;
  assign step_counter_o = step_q;
  assign running_o      = (state_q == PRIME) || (state_q == RUN);
  assign done_o         = done_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sequence_stepper.sv
// Scoreboard bench for sequence_stepper: expected steps are queued when enable is driven and
// checked by a monitor on every step_strobe; each test task checks its own side effects.
module tb_sequence_stepper;

  localparam int AW = 2;

  typedef struct {
    logic [127:0] data;
    logic [31:0]  step;
    int           cycle;
    logic         uf;
  } rec_t;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic [31:0]   stepPeriod = 32'd4;
  logic [31:0]   totalSteps = 32'd0;
  logic [31:0]   writePtr = 32'd0;
  logic          bramEn;
  logic [AW-1:0] bramAddr;
  logic [127:0]  bramRdata = '0;
  logic [127:0]  seqData;
  logic          stepStrobe;
  logic [31:0]   stepCounter;
  logic          running;
  logic          done;
  logic          underflow;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int strobeCount = 0;
  rec_t expQ[$];
  int enCycQ[$];
  logic [AW-1:0] enAddrQ[$];
  rec_t scbExp;

  sequence_stepper #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .enable_i      (enable),
    .step_period_i (stepPeriod),
    .total_steps_i (totalSteps),
    .write_ptr_i   (writePtr),
    .bram_en_o     (bramEn),
    .bram_addr_o   (bramAddr),
    .bram_rdata_i  (bramRdata),
    .seq_data_o    (seqData),
    .step_strobe_o (stepStrobe),
    .step_counter_o(stepCounter),
    .running_o     (running),
    .done_o        (done),
    .underflow_o   (underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic [127:0] memWord(input logic [31:0] a);
    return {32'h5EC0_0000 | a, 32'hFFFF_0000 ^ a, 32'h0123_4567, a + 32'd1};
  endfunction

  function automatic logic availModel(input logic [31:0] wp, input logic [31:0] s);
    logic [31:0] d;
    d = wp - s;
    return (d >= 32'd1) && (d <= 32'h8000_0000);
  endfunction

  always @(posedge clk) begin
    if (bramEn) bramRdata <= memWord(32'(bramAddr));
  end

  // Scoreboard monitor: every strobe pops one expected step and compares it.
  always @(negedge clk) begin
    if (aresetn && stepStrobe) begin
      strobeCount = strobeCount + 1;
      checks = checks + 1;
      if (expQ.size() == 0) begin
        errors = errors + 1;
        $display("[TB] FAIL unexpected_strobe got step %0d at cycle %0d, required no strobe", stepCounter, cycleCount);
      end else begin
        scbExp = expQ.pop_front();
        if (seqData !== scbExp.data || stepCounter !== scbExp.step ||
            cycleCount !== scbExp.cycle || underflow !== scbExp.uf) begin
          errors = errors + 1;
          $display("[TB] FAIL step_%0d got data=%h step=%0d cycle=%0d uf=%b, required data=%h step=%0d cycle=%0d uf=%b",
                   scbExp.step, seqData, stepCounter, cycleCount, underflow,
                   scbExp.data, scbExp.step, scbExp.cycle, scbExp.uf);
        end
      end
    end
    if (aresetn && bramEn) begin
      enCycQ.push_back(cycleCount);
      enAddrQ.push_back(bramAddr);
    end
  end

  task automatic pushExp(input logic [127:0] d, input logic [31:0] s, input int cyc, input logic uf);
    rec_t r;
    r.data = d;
    r.step = s;
    r.cycle = cyc;
    r.uf = uf;
    expQ.push_back(r);
  endtask

  task automatic planSteps(input int pEff, input logic [31:0] wp, input int start, input int count);
    logic uf;
    logic av;
    logic [31:0] s;
    uf = 1'b0;
    for (int k = 0; k < count; k++) begin
      s = 32'(k);
      av = availModel(wp, s);
      uf = uf | ~av;
      pushExp(av ? memWord(s & 32'd3) : '0, s, start + 3 + pEff * k, uf);
    end
  endtask

  task automatic startRun(input logic [31:0] p, input logic [31:0] n, input logic [31:0] wp, output int start);
    stepPeriod = p;
    totalSteps = n;
    writePtr = wp;
    expQ.delete();
    enCycQ.delete();
    enAddrQ.delete();
    @(posedge clk);
    #1;
    enable = 1'b1;
    start = cycleCount;
  endtask

  task automatic waitRun(input int maxCycles, input int strobes);
    int seen0;
    seen0 = strobeCount;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      #1;
      if (totalSteps != 0 && done) return;
      if (strobes > 0 && strobeCount - seen0 >= strobes) return;
    end
  endtask

  task automatic stopRun();
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if ({bramEn, stepStrobe, running, done, underflow} !== 5'b0) begin
      errors = errors + 1;
      $display("[TB] FAIL reset_flags got %b, required 00000", {bramEn, stepStrobe, running, done, underflow});
    end
    checks = checks + 1;
    if (seqData !== '0 || stepCounter !== 32'd0 || bramAddr !== '0) begin
      errors = errors + 1;
      $display("[TB] FAIL reset_data got seq=%h cnt=%0d addr=%0d, required all 0", seqData, stepCounter, bramAddr);
    end
    aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int start;
    startRun(32'd5, 32'd4, 32'd100, start);
    planSteps(5, 32'd100, start, 4);
    waitRun(60, 0);
    checks = checks + 1;
    if (done !== 1'b1 || cycleCount !== start + 23 || seqData !== '0 || running !== 1'b0) begin
      errors = errors + 1;
      $display("[TB] FAIL basic_done got done=%b cycle=%0d seq=%h run=%b, required done=1 cycle=%0d seq=0 run=0",
               done, cycleCount, seqData, running, start + 23);
    end
    repeat (6) @(posedge clk);
    #1;
    checks = checks + 1;
    if (enCycQ.size() !== 4 || expQ.size() !== 0) begin
      errors = errors + 1;
      $display("[TB] FAIL basic_counts got en=%0d pending=%0d, required en=4 pending=0", enCycQ.size(), expQ.size());
    end
    for (int k = 0; k < 4 && k < enCycQ.size(); k++) begin
      checks = checks + 1;
      if (enCycQ[k] !== (k == 0 ? start + 1 : start + 1 + 5 * k) || enAddrQ[k] !== AW'(k)) begin
        errors = errors + 1;
        $display("[TB] FAIL basic_fetch_%0d got cycle=%0d addr=%0d, required cycle=%0d addr=%0d",
                 k, enCycQ[k], enAddrQ[k], (k == 0 ? start + 1 : start + 1 + 5 * k), k);
      end
    end
    stopRun();
    checks = checks + 1;
    if (done !== 1'b0 || seqData !== '0) begin
      errors = errors + 1;
      $display("[TB] FAIL basic_idle got done=%b seq=%h, required done=0 seq=0", done, seqData);
    end
  endtask

  task automatic test_min_period();
    int start;
    startRun(32'd1, 32'd3, 32'd100, start);
    planSteps(4, 32'd100, start, 3);
    waitRun(60, 0);
    checks = checks + 1;
    if (done !== 1'b1 || cycleCount !== start + 15 || enCycQ.size() !== 3) begin
      errors = errors + 1;
      $display("[TB] FAIL minp_done got done=%b cycle=%0d en=%0d, required done=1 cycle=%0d en=3",
               done, cycleCount, enCycQ.size(), start + 15);
    end
    for (int k = 1; k < enCycQ.size(); k++) begin
      checks = checks + 1;
      if (enCycQ[k] - enCycQ[k-1] !== 4) begin
        errors = errors + 1;
        $display("[TB] FAIL minp_en_gap_%0d got %0d, required 4", k, enCycQ[k] - enCycQ[k-1]);
      end
    end
    stopRun();
  endtask

  task automatic test_period_change();
    int start;
    startRun(32'd5, 32'd3, 32'd100, start);
    pushExp(memWord(32'd0), 32'd0, start + 3, 1'b0);
    pushExp(memWord(32'd1), 32'd1, start + 8, 1'b0);
    pushExp(memWord(32'd2), 32'd2, start + 14, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    stepPeriod = 32'd6;
    waitRun(60, 0);
    checks = checks + 1;
    if (done !== 1'b1 || cycleCount !== start + 20 || expQ.size() !== 0) begin
      errors = errors + 1;
      $display("[TB] FAIL period_change got done=%b cycle=%0d pending=%0d, required done=1 cycle=%0d pending=0",
               done, cycleCount, expQ.size(), start + 20);
    end
    stopRun();
  endtask

  task automatic test_underflow();
    int start;
    startRun(32'd4, 32'd4, 32'd2, start);
    planSteps(4, 32'd2, start, 4);
    waitRun(60, 0);
    checks = checks + 1;
    if (done !== 1'b1 || underflow !== 1'b1 || expQ.size() !== 0) begin
      errors = errors + 1;
      $display("[TB] FAIL underflow_end got done=%b uf=%b pending=%0d, required done=1 uf=1 pending=0",
               done, underflow, expQ.size());
    end
  endtask

  task automatic test_abort_restart();
    int start;
    stopRun();
    checks = checks + 1;
    if (underflow !== 1'b1 || running !== 1'b0) begin
      errors = errors + 1;
      $display("[TB] FAIL abort_sticky got uf=%b run=%b, required uf=1 run=0", underflow, running);
    end
    startRun(32'd4, 32'd0, 32'd1000, start);
    planSteps(4, 32'd1000, start, 2);
    @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (underflow !== 1'b0 || running !== 1'b1 || bramEn !== 1'b1 || bramAddr !== '0) begin
      errors = errors + 1;
      $display("[TB] FAIL restart_prime got uf=%b run=%b en=%b addr=%0d, required uf=0 run=1 en=1 addr=0",
               underflow, running, bramEn, bramAddr);
    end
    waitRun(40, 2);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (seqData !== '0 || running !== 1'b0 || stepStrobe !== 1'b0 || expQ.size() !== 0) begin
      errors = errors + 1;
      $display("[TB] FAIL abort_idle got seq=%h run=%b strobe=%b pending=%0d, required seq=0 run=0 strobe=0 pending=0",
               seqData, running, stepStrobe, expQ.size());
    end
    startRun(32'd4, 32'd0, 32'd1000, start);
    planSteps(4, 32'd1000, start, 1);
    waitRun(20, 1);
    stopRun();
  endtask

  task automatic test_ring_wrap();
    int start;
    startRun(32'd4, 32'd0, 32'd1000, start);
    planSteps(4, 32'd1000, start, 6);
    waitRun(60, 6);
    stopRun();
    checks = checks + 1;
    if (enAddrQ.size() < 6 || expQ.size() !== 0) begin
      errors = errors + 1;
      $display("[TB] FAIL ring_counts got en=%0d pending=%0d, required en>=6 pending=0", enAddrQ.size(), expQ.size());
    end
    for (int k = 0; k < 6 && k < enAddrQ.size(); k++) begin
      checks = checks + 1;
      if (enAddrQ[k] !== AW'(k % 4)) begin
        errors = errors + 1;
        $display("[TB] FAIL ring_addr_%0d got %0d, required %0d", k, enAddrQ[k], k % 4);
      end
    end
  endtask

  task automatic test_wptr_wrap();
    int start;
    startRun(32'd4, 32'd3, 32'h8000_0001, start);
    planSteps(4, 32'h8000_0001, start, 3);
    waitRun(40, 0);
    stopRun();
    startRun(32'd4, 32'd1, 32'h8000_0000, start);
    planSteps(4, 32'h8000_0000, start, 1);
    waitRun(40, 0);
    checks = checks + 1;
    if (done !== 1'b1 || underflow !== 1'b0 || expQ.size() !== 0) begin
      errors = errors + 1;
      $display("[TB] FAIL wptr_wrap got done=%b uf=%b pending=%0d, required done=1 uf=0 pending=0",
               done, underflow, expQ.size());
    end
    stopRun();
  endtask

  task automatic test_reset_in_run();
    int start;
    startRun(32'd4, 32'd0, 32'd1000, start);
    planSteps(4, 32'd1000, start, 2);
    waitRun(40, 2);
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    checks = checks + 1;
    if ({bramEn, stepStrobe, running, done, underflow} !== 5'b0 || seqData !== '0 || stepCounter !== 32'd0) begin
      errors = errors + 1;
      $display("[TB] FAIL reset_in_run got flags=%b seq=%h cnt=%0d, required all 0",
               {bramEn, stepStrobe, running, done, underflow}, seqData, stepCounter);
    end
    enable = 1'b0;
    aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_min_period();
    test_period_change();
    test_underflow();
    test_abort_restart();
    test_ring_wrap();
    test_wptr_wrap();
    test_reset_in_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
